rf_control_unit: RTL and testbench
==================================

# rf_control_unit

- Moore-style instruction sequencer that drives the 16x16 register file, data memory and ALU of the LabB processor.
- Fetches 16-bit instructions by PC, decodes the opcode, and issues the register-file read/write addresses and enables, data-memory address/write, RF write-data mux select and ALU select for each instruction class.
- Sits between the instruction ROM and the datapath; it is the sole owner of all register-file control pins.

## Interface
Parameters:
- PC_W, 7, instruction address width; PC wraps modulo 2^PC_W.
- DA_W, 8, data-memory address width; must equal 8 (IR[11:4]).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- IR_data  in  16  instruction word at PC_addr; stable by the rising edge that leaves FETCH.
- PC_addr  out  PC_W  instruction address (register).
- D_addr  out  DA_W  data-memory address.
- D_wr  out  1  data-memory write strobe.
- RF_s  out  1  RF write-data select: 0 = ALU, 1 = data memory.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr, RF_Rb_addr  out  4 each  read addresses.
- RF_Ra_en, RF_Rb_en  out  1 each  read enables.
- ALU_s  out  3  0 = none, 1 = A+B, 2 = A−B.
- State  out  4  current state code (debug).
- Halted  out  1  high while in HALT.
- Step  in  1  single-step request; present only with CU_SINGLE_STEP_EN.

## Operation
- Internal IR register (16 bits) is loaded from IR_data on the edge leaving FETCH. PC increments on the same edge.
- Opcode is IR[15:12]:
  - 0 NOOP.
  - 1 STORE: D[IR[11:4]] ← R[IR[3:0]].
  - 2 LOAD: R[IR[3:0]] ← D[IR[11:4]].
  - 3 ADD: R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]].
  - 4 SUB: R[IR[3:0]] ← R[IR[11:8]] − R[IR[7:4]].
  - 5 HALT.
  - 6–15: treated as NOOP.
- State codes:
  - INIT=0, FETCH=1, DECODE=2, NOOP=3.
  - LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8.
  - HALT=9, WAIT=10.
- Transitions:
  - INIT→FETCH→DECODE→{NOOP|LOAD_A|STORE|ADD|SUB|HALT}.
  - LOAD_A→LOAD_B.
  - NOOP/LOAD_B/STORE/ADD/SUB→FETCH (→WAIT with step mode).
  - HALT→HALT until Rst.
- Outputs are decoded from State and IR only; any output not listed for a state is 0:
  - LOAD_A: D_addr=IR[11:4].
  - LOAD_B: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - STORE: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], RF_Ra_en=1, D_wr=1.
  - ADD/SUB: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], both read enables 1, RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s=1 (ADD) or 2 (SUB).
  - HALT: Halted=1.
- Default address outputs are 0 outside the states that drive them.
- Arithmetic: PC is PC_W bits unsigned and wraps from 2^PC_W−1 to 0. The ALU owns the data-width arithmetic; no other arithmetic here.
- Rd equal to Ra or Rb is legal. The read occurs combinationally within the execute cycle; the write commits at its closing edge.

## Timing
- Reset (Rst=0, asynchronous): State=INIT, PC_addr=0, IR=0, all strobes/enables/selects 0, Halted=0.
- First FETCH is one cycle after Rst deasserts (INIT lasts one cycle).
- Cycles per instruction: NOOP, STORE, ADD, SUB = 3; LOAD = 4; HALT = 2 then holds.
- RF_W_en and D_wr are asserted for exactly one cycle per write instruction.
- Reset mid-instruction aborts immediately; no write enable survives the reset edge.
- PC sequence for consecutive instructions: 0,1,2,… one increment per FETCH.

## Configuration
- CU_SINGLE_STEP_EN defined:
  - Step port exists.
  - After each completed instruction, the controller enters WAIT with all strobes 0.
  - It leaves WAIT to FETCH on the first cycle where Step=1 and the previous-cycle Step=0 (registered rising-edge detect, reset to 0).
  - Holding Step high advances only one instruction.
- Not defined: no Step port, no WAIT state; execution free-runs FETCH-to-FETCH.

## Test plan
- Reset: hold Rst=0 for 3 cycles mid-ADD → State=0, PC_addr=0, RF_W_en=0, D_wr=0, and INIT→FETCH one cycle after release.
- LOAD: IR_data=16'h2A53 → LOAD_A with D_addr=8'hA5. Next cycle: RF_W_en=1, RF_s=1, RF_W_addr=3, D_addr=8'hA5. FETCH resumes 4 cycles after the prior FETCH.
- STORE then ADD/SUB:
  - 16'h1203 → D_wr=1, D_addr=8'h20, RF_Ra_addr=3, RF_Ra_en=1 for one cycle.
  - 16'h3124 → ALU_s=1, RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=4, RF_W_en=1.
  - 16'h4124 → ALU_s=2.
- Unknown opcode and wrap: PC preloaded to 127 via NOOPs (opcode 16'hF000) → no strobes asserted, PC_addr goes 127→0.
- HALT: 16'h5000 → Halted=1, State=9, PC_addr frozen and all strobes 0 for 20 cycles; Rst clears it.
- Single-step (macro defined): after an ADD, State=10 until a Step 0→1 edge. Step held high for 10 cycles executes exactly one further instruction.

Source files
------------

// File: rtl/rf_control_unit.sv
// Purpose: Moore sequencer for the LabB datapath; owns every register-file, data-memory and ALU control pin.
// Latency: 3 cycles per NOOP/STORE/ADD/SUB, 4 per LOAD, HALT holds after 2; one PC increment per FETCH.
// Backpressure: none, free-running; with CU_SINGLE_STEP_EN each instruction waits for a Step rising edge.
module rf_control_unit #(
  parameter int PC_W = 7,
  parameter int DA_W = 8
) (
  input  logic            Clk,
  input  logic            Rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic            Step,
`endif
  input  logic [15:0]     IR_data,
  output logic [PC_W-1:0] PC_addr,
  output logic [DA_W-1:0] D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_Ra_en,
  output logic            RF_Rb_en,
  output logic [2:0]      ALU_s,
  output logic [3:0]      State,
  output logic            Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT = 4'd10
`endif
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [3:0]      opcode;

  assign opcode = ir[15:12];

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  // Registered copy of Step so a held-high request only counts once.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) step_q <= 1'b0;
    else      step_q <= Step;
  end

  assign step_rise = Step && !step_q;
`endif

  // State, PC and IR registers; IR captures the instruction on the edge leaving FETCH.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) begin
        ir <= IR_data;
        pc <= pc + PC_W'(1);
      end
    end
  end

  // Next-state: decode dispatches on the opcode, execute states return to FETCH (or WAIT).
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:   state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'd1:    state_nx = S_STORE;
          4'd2:    state_nx = S_LOAD_A;
          4'd3:    state_nx = S_ADD;
          4'd4:    state_nx = S_SUB;
          4'd5:    state_nx = S_HALT;
          default: state_nx = S_NOOP;
        endcase
      end
      S_LOAD_A: state_nx = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: begin
`ifdef CU_SINGLE_STEP_EN
        state_nx = S_WAIT;
`else
        state_nx = S_FETCH;
`endif
      end
      S_HALT:   state_nx = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_WAIT:   if (step_rise) state_nx = S_FETCH;
`endif
      default:  state_nx = S_INIT;
    endcase
  end

  // Moore outputs decoded from the state and the latched IR; everything idles at 0.
  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    RF_Ra_en   = 1'b0;
    RF_Rb_en   = 1'b0;
    ALU_s      = 3'd0;
    Halted     = 1'b0;
    case (state)
      S_LOAD_A: D_addr = DA_W'(ir[11:4]);
      S_LOAD_B: begin
        D_addr    = DA_W'(ir[11:4]);
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_en   = 1'b1;
      end
      S_STORE: begin
        D_addr     = DA_W'(ir[11:4]);
        RF_Ra_addr = ir[3:0];
        RF_Ra_en   = 1'b1;
        D_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        RF_Ra_en   = 1'b1;
        RF_Rb_en   = 1'b1;
        RF_W_addr  = ir[3:0];
        RF_W_en    = 1'b1;
        ALU_s      = (state == S_ADD) ? 3'd1 : 3'd2;
      end
      S_HALT:   Halted = 1'b1;
      default:  ;
    endcase
  end

  assign PC_addr = pc;
  assign State   = state;

endmodule

// File: tb/tb_rf_control_unit.sv
module tb_rf_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] pc;
    logic [7:0] da;
    logic       dwr;
    logic       rfs;
    logic [3:0] wa;
    logic       wen;
    logic [3:0] ra;
    logic       raen;
    logic [3:0] rb;
    logic       rben;
    logic [2:0] alu;
    logic       hlt;
  } obs_t;

  typedef struct {
    obs_t  o;
    string nm;
  } exp_t;

  logic        Clk;
  logic        Rst;
  logic [15:0] IR_data;
  logic [6:0]  PC_addr;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, RF_W_en, RF_Ra_en, RF_Rb_en, Halted;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s;
`ifdef CU_SINGLE_STEP_EN
  logic        Step;
`endif

  rf_control_unit #(.PC_W(7), .DA_W(8)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
`ifdef CU_SINGLE_STEP_EN
    .Step       (Step),
`endif
    .IR_data    (IR_data),
    .PC_addr    (PC_addr),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .RF_Ra_en   (RF_Ra_en),
    .RF_Rb_en   (RF_Rb_en),
    .ALU_s      (ALU_s),
    .State      (State),
    .Halted     (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t       sb[$];
  exp_t       cur;
  obs_t       act;
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [6:0] pc_m;

  assign act = {State, PC_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Ra_en, RF_Rb_addr, RF_Rb_en, ALU_s, Halted};

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      n_chk++;
      if (act !== cur.o) begin
        n_fail++;
        $display("FAIL %s: actual %h required %h", cur.nm, act, cur.o);
      end
    end
  end

  initial begin
    repeat (20000) @(posedge Clk);
    n_fail++;
    $display("FAIL watchdog expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic obs_t idle(input logic [3:0] st, input logic [6:0] pc);
    obs_t o;
    o    = '0;
    o.st = st;
    o.pc = pc;
    return o;
  endfunction

  // Queue the expectation for the cycle now in progress, then advance one clock.
  task automatic chk(input obs_t e, input string nm);
    exp_t x;
    x.o  = e;
    x.nm = nm;
    sb.push_back(x);
    @(posedge Clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ir, input string nm, input bit auto_step);
    obs_t o;
    IR_data = ir;
    chk(idle(4'd1, pc_m), {nm, " fetch"});
    IR_data = ~ir;
    pc_m = pc_m + 7'd1;
    chk(idle(4'd2, pc_m), {nm, " decode"});
    case (ir[15:12])
      4'd1: begin
        o = idle(4'd6, pc_m); o.da = ir[11:4]; o.ra = ir[3:0]; o.raen = 1'b1; o.dwr = 1'b1;
        chk(o, {nm, " store"});
      end
      4'd2: begin
        o = idle(4'd4, pc_m); o.da = ir[11:4];
        chk(o, {nm, " load_a"});
        o = idle(4'd5, pc_m); o.da = ir[11:4]; o.rfs = 1'b1; o.wa = ir[3:0]; o.wen = 1'b1;
        chk(o, {nm, " load_b"});
      end
      4'd3, 4'd4: begin
        o = idle((ir[15:12] == 4'd3) ? 4'd7 : 4'd8, pc_m);
        o.ra = ir[11:8]; o.rb = ir[7:4]; o.raen = 1'b1; o.rben = 1'b1;
        o.wa = ir[3:0]; o.wen = 1'b1; o.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
        chk(o, {nm, " exec"});
      end
      4'd5: begin
        o = idle(4'd9, pc_m); o.hlt = 1'b1;
        chk(o, {nm, " halt"});
      end
      default: chk(idle(4'd3, pc_m), {nm, " noop"});
    endcase
`ifdef CU_SINGLE_STEP_EN
    if (ir[15:12] != 4'd5 && auto_step) begin
      Step = 1'b1;
      chk(idle(4'd10, pc_m), {nm, " wait"});
      Step = 1'b0;
    end
`else
    if (auto_step) pc_m = pc_m;
`endif
  endtask

  initial begin
    obs_t h;
    int   w;
    Rst     = 1'b0;
    IR_data = 16'h0000;
`ifdef CU_SINGLE_STEP_EN
    Step    = 1'b0;
`endif
    pc_m    = 7'd0;
    @(posedge Clk);
    #1;
    chk(idle(4'd0, 7'd0), "reset");
    chk(idle(4'd0, 7'd0), "reset");
    n_chk++;
    if (State !== 4'd0 || PC_addr !== 7'd0 || RF_W_en !== 1'b0 || D_wr !== 1'b0 ||
        RF_Ra_en !== 1'b0 || RF_Rb_en !== 1'b0 || RF_s !== 1'b0 || ALU_s !== 3'd0 ||
        Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state: State=%0d PC=%0d W_en=%b D_wr=%b Halted=%b",
               State, PC_addr, RF_W_en, D_wr, Halted);
    end
    Rst = 1'b1;
    chk(idle(4'd0, 7'd0), "init");

    run_instr(16'h2A53, "load 2A53", 1'b1);
    run_instr(16'h1203, "store 1203", 1'b1);
    run_instr(16'h3124, "add 3124", 1'b1);
    run_instr(16'h4124, "sub 4124", 1'b1);
    run_instr(16'h0000, "noop", 1'b1);
    run_instr(16'h6ABC, "op6", 1'b1);
    run_instr(16'h3337, "add rd=ra", 1'b1);

    // Reset asserted in the execute cycle of an ADD.
    IR_data = 16'h3124;
    chk(idle(4'd1, pc_m), "midadd fetch");
    IR_data = 16'h0000;
    pc_m = pc_m + 7'd1;
    chk(idle(4'd2, pc_m), "midadd decode");
    Rst = 1'b0;
    #1;
    repeat (3) chk(idle(4'd0, 7'd0), "midadd reset");
    Rst = 1'b1;
    chk(idle(4'd0, 7'd0), "midadd init");
    pc_m = 7'd0;

    // Unknown opcode NOOPs walk the PC through 127 and back to 0.
    for (int i = 0; i < 128; i++) run_instr(16'hF000, "opF", 1'b1);
    run_instr(16'h0000, "after wrap", 1'b1);

`ifdef CU_SINGLE_STEP_EN
    // Step held high for 10 cycles releases exactly one instruction.
    run_instr(16'h3124, "ss add", 1'b0);
    repeat (3) chk(idle(4'd10, pc_m), "ss idle wait");
    Step    = 1'b1;
    chk(idle(4'd10, pc_m), "ss edge wait");
    IR_data = 16'h0000;
    chk(idle(4'd1, pc_m), "ss fetch");
    pc_m = pc_m + 7'd1;
    chk(idle(4'd2, pc_m), "ss decode");
    chk(idle(4'd3, pc_m), "ss noop");
    repeat (6) chk(idle(4'd10, pc_m), "ss held wait");
    Step = 1'b0;
    chk(idle(4'd10, pc_m), "ss low wait");
    Step = 1'b1;
    chk(idle(4'd10, pc_m), "ss second edge");
    Step = 1'b0;
    run_instr(16'h1203, "ss store", 1'b1);
`endif

    // HALT freezes the PC and holds all strobes low until reset.
    run_instr(16'h5000, "halt", 1'b1);
    h = idle(4'd9, pc_m);
    h.hlt = 1'b1;
    IR_data = 16'h2A53;
    repeat (20) chk(h, "halt hold");
    Rst = 1'b0;
    #1;
    chk(idle(4'd0, 7'd0), "halt reset");
    Rst = 1'b1;
    chk(idle(4'd0, 7'd0), "halt init");
    pc_m = 7'd0;
    run_instr(16'h4567, "post halt sub", 1'b1);

    IR_data = 16'h0000;
    w = 0;
    while (State !== 4'd1 && w < 8) begin
      @(posedge Clk);
      #1;
      w++;
    end
    n_chk++;
    if (State !== 4'd1) begin
      n_fail++;
      $display("FAIL wait for FETCH expired after %0d cycles: State=%0d", w, State);
    end

    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
